alu32_result_stage: RTL and testbench



---
 rtl/alu32_result_stage.sv | 128 ++++++++++++
 tb/tb_alu32_result_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu32_result_stage.sv
// Registered result stage of the 32-bit ALU: eight-way result mux with NZCV
// flags captured into a one-entry output register under valid/ready handshake.
module alu32_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    typedef enum logic [2:0] {
        OP_NOT_A = 3'b000,
        OP_NOT_B = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ADD   = 3'b110,
        OP_SUB   = 3'b111
    } alu_op_e;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic             accept;
    logic [WIDTH-1:0] b_addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    // NOTE: in_ready is forced low during reset, so a handshake on a reset edge is never accepted.
    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Shared adder: op[0] selects subtract as A + ~B + 1.
    always_comb begin
        b_addend = op[0] ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_addend} + {{WIDTH{1'b0}}, op[0]};
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (alu_op_e'(op))
            OP_NOT_A: res = ~a;
            OP_NOT_B: res = ~b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_XNOR:  res = ~(a ^ b);
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = res;
            n_d         = res[WIDTH-1];
            z_d         = (res == '0);
            c_d         = res_c;
            v_d         = res_v;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign n         = n_q;
    assign z         = z_q;
    assign c         = c_q;
    assign v         = v_q;

endmodule

// File: tb/tb_alu32_result_stage.sv
// Directed testbench for alu32_result_stage with hand-computed expected values.
module tb_alu32_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        n, z, c, v;

    int total = 0;
    int bad   = 0;

    alu32_result_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] logic_flags(input logic [31:0] r);
        return {r[31], (r == 32'h0), 1'b0, 1'b0};
    endfunction

    logic [31:0] sweep_exp [6];
    logic [31:0] b2b_exp   [8];
    logic [3:0]  b2b_flags [8];

    initial begin
        sweep_exp = '{32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000,
                      32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F};
        b2b_exp   = '{32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 32'hFFF0FFF0,
                      32'h0FF00FF0, 32'hF00FF00F, 32'hEFF1EFF0, 32'hF1EFF1F0};
        b2b_flags = '{4'b0000, 4'b0000, 4'b1000, 4'b1000,
                      4'b0000, 4'b1000, 4'b1010, 4'b1000};

        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 32'h1234_5678;
        b         = 32'h1111_1111;
        op        = 3'b110;
        #1;
        check("in_ready_in_reset", {31'h0, in_ready}, 32'h0);
        step();
        step();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_y", y, 32'h0);
        check("rst_flags", {28'h0, n, z, c, v}, 32'h0);

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("in_ready_after_reset", {31'h0, in_ready}, 32'h1);

        // ADD wrap
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001; op = 3'b110;
        step();
        check("add_wrap_valid", {31'h0, out_valid}, 32'h1);
        check("add_wrap_y", y, 32'h0);
        check("add_wrap_nzcv", {28'h0, n, z, c, v}, 32'h6);

        // SUB signed overflow, then SUB with borrow
        a = 32'h80000000; b = 32'h00000001; op = 3'b111;
        step();
        check("sub_ovf_y", y, 32'h7FFFFFFF);
        check("sub_ovf_nzcv", {28'h0, n, z, c, v}, 32'h3);
        a = 32'h00000000; b = 32'h00000001;
        step();
        check("sub_borrow_y", y, 32'hFFFFFFFF);
        check("sub_borrow_nzcv", {28'h0, n, z, c, v}, 32'h8);

        // Logic sweep
        a = 32'hF0F0F0F0; b = 32'hFF00FF00;
        for (int i = 0; i < 6; i++) begin
            op = 3'(i);
            step();
            check($sformatf("logic_y_op%0d", i), y, sweep_exp[i]);
            check($sformatf("logic_nzcv_op%0d", i), {28'h0, n, z, c, v},
                  {28'h0, logic_flags(sweep_exp[i])});
        end

        // Backpressure
        a = 32'd5; b = 32'd7; op = 3'b110;
        step();
        check("bp_first_y", y, 32'd12);
        out_ready = 1'b0;
        a = 32'd100; b = 32'd1;
        #1;
        check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_hold_y_%0d", i), y, 32'd12);
            check($sformatf("bp_hold_valid_%0d", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("bp_hold_ready_%0d", i), {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'h0, in_ready}, 32'h1);
        step();
        check("bp_release_y", y, 32'd101);
        check("bp_release_valid", {31'h0, out_valid}, 32'h1);

        // Back-to-back, all eight ops
        a = 32'hF0F0F0F0; b = 32'hFF00FF00;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            check($sformatf("b2b_y_%0d", i), y, b2b_exp[i]);
            check($sformatf("b2b_nzcv_%0d", i), {28'h0, n, z, c, v}, {28'h0, b2b_flags[i]});
            check($sformatf("b2b_valid_%0d", i), {31'h0, out_valid}, 32'h1);
        end

        // Drain with no new input
        in_valid = 1'b0;
        a = 32'hxxxxxxxx; b = 32'hxxxxxxxx; op = 3'bxxx;
        step();
        check("drain_valid", {31'h0, out_valid}, 32'h0);
        check("idle_y_no_x", {31'h0, ^y === 1'bx}, 32'h0);

        // Reset during a stall
        in_valid = 1'b1; a = 32'd3; b = 32'd4; op = 3'b011;
        step();
        check("stall_pre_y", y, 32'd7);
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("stall_rst_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        check("stall_rst_valid", {31'h0, out_valid}, 32'h0);
        check("stall_rst_y", y, 32'h0);
        check("stall_rst_flags", {28'h0, n, z, c, v}, 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_nothing_captured", {31'h0, out_valid}, 32'h0);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
